// File: rtl/mac_dispatcher.sv
// mac_dispatcher: buffers (a,b,c,d) tuples in a FIFO and issues them one at a time to a start/busy MAC engine
// Ports:
//   clk, i_reset_n            clock, synchronous active-low reset
//   i_in_valid/o_in_ready     operand push handshake, i_in_a..i_in_d operand tuple
//   o_level                   FIFO occupancy
//   o_eng_a..o_eng_d          registered operands to engine, o_eng_start start request
//   i_eng_busy, i_eng_out     engine busy and result (valid when busy falls)
//   o_res_valid/i_res_ready   result handshake, o_res_data result
//   o_err_timeout             sticky: an issue was aborted because the engine never went busy
module mac_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       i_reset_n,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [7:0]                 i_in_a,
  input  logic [7:0]                 i_in_b,
  input  logic [7:0]                 i_in_c,
  input  logic [7:0]                 i_in_d,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic [7:0]                 o_eng_a,
  output logic [7:0]                 o_eng_b,
  output logic [7:0]                 o_eng_c,
  output logic [7:0]                 o_eng_d,
  output logic                       o_eng_start,
  input  logic                       i_eng_busy,
  input  logic [15:0]                i_eng_out,
  output logic                       o_res_valid,
  input  logic                       i_res_ready,
  output logic [15:0]                o_res_data,
  output logic                       o_err_timeout
);
  localparam int LW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {SYNC, IDLE, ISSUE, WAIT} state_t;

  state_t        r_state, w_next;
  logic [31:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [TW-1:0] r_timer;
  logic [31:0]   r_eng_ops;
  logic          r_eng_start, r_res_valid, r_err_timeout;
  logic [15:0]   r_res_data;
  logic          w_push, w_pop, w_abort;

  assign o_in_ready    = r_level < LW'(DEPTH);
  assign o_level       = r_level;
  assign {o_eng_a, o_eng_b, o_eng_c, o_eng_d} = r_eng_ops;
  assign o_eng_start   = r_eng_start;
  assign o_res_valid   = r_res_valid;
  assign o_res_data    = r_res_data;
  assign o_err_timeout = r_err_timeout;

  assign w_push  = i_in_valid && o_in_ready;
  // holding back while a result is unconsumed keeps the engine from overwriting it
  assign w_pop   = r_state == IDLE && r_level != '0 && !r_res_valid;
  // abort on the TIMEOUT-th ISSUE edge without busy
  assign w_abort = r_state == ISSUE && !i_eng_busy && r_timer == TW'(TIMEOUT-1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      SYNC:    w_next = i_eng_busy ? SYNC : IDLE;
      IDLE:    w_next = w_pop ? ISSUE : IDLE;
      ISSUE:   w_next = i_eng_busy ? WAIT : (w_abort ? SYNC : ISSUE);
      WAIT:    w_next = i_eng_busy ? WAIT : IDLE;
      default: w_next = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_reset_n) r_state <= SYNC;
    else            r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_in_a, i_in_b, i_in_c, i_in_d};
  end

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      r_eng_ops     <= '0;
      r_eng_start   <= 1'b0;
      r_timer       <= '0;
      r_res_valid   <= 1'b0;
      r_res_data    <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_pop) begin
        r_eng_ops   <= r_mem[r_rd_ptr];
        r_eng_start <= 1'b1;
        r_timer     <= '0;
      end else if (r_state == ISSUE) begin
        if (i_eng_busy) r_eng_start <= 1'b0;
        else if (w_abort) begin
          r_eng_start   <= 1'b0;
          r_err_timeout <= 1'b1;
        end else r_timer <= r_timer + TW'(1);
      end
      if (r_state == WAIT && !i_eng_busy) begin
        r_res_data  <= i_eng_out;
        r_res_valid <= 1'b1;
      end else if (r_res_valid && i_res_ready) r_res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mac_dispatcher.sv
// tb_mac_dispatcher: directed self-checking bench for mac_dispatcher with a behavioural MAC engine
module tb_mac_dispatcher;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0, in_b = '0, in_c = '0, in_d = '0;
  logic [2:0]  level;
  logic [7:0]  eng_a, eng_b, eng_c, eng_d;
  logic        eng_start;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [15:0] res_data;
  logic        err_timeout;

  int vectors = 0;
  int miscompares = 0;

  // engine: sees start while idle, busy for 3 cycles, result ready when busy falls
  logic        e_busy = 1'b0;
  logic [1:0]  e_cnt = '0;
  logic [15:0] e_out = '0;
  bit          dead = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dead) begin
      e_busy <= 1'b0;
      e_cnt  <= '0;
    end else if (e_busy) begin
      e_cnt <= e_cnt - 2'd1;
      if (e_cnt == 2'd1) e_busy <= 1'b0;
    end else if (eng_start) begin
      e_busy <= 1'b1;
      e_cnt  <= 2'd3;
      e_out  <= {8'd0, eng_a} * {8'd0, eng_b} * {8'd0, eng_c} + {8'd0, eng_d};
    end
  end

  mac_dispatcher #(.DEPTH(4), .TIMEOUT(15)) dut (
    .clk(clk), .i_reset_n(reset_n),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_a(in_a), .i_in_b(in_b), .i_in_c(in_c), .i_in_d(in_d),
    .o_level(level),
    .o_eng_a(eng_a), .o_eng_b(eng_b), .o_eng_c(eng_c), .o_eng_d(eng_d),
    .o_eng_start(eng_start), .i_eng_busy(e_busy), .i_eng_out(e_out),
    .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_data(res_data),
    .o_err_timeout(err_timeout)
  );

  int peak = 0;
  int viol = 0;
  bit prev_busy = 1'b0;

  always @(negedge clk) begin
    if (int'(level) > peak) peak = int'(level);
    if (eng_start && e_busy && prev_busy) viol++;
    prev_busy = e_busy;
  end

  task automatic push_tuple(input logic [7:0] a, b, c, d);
    in_valid = 1'b1;
    {in_a, in_b, in_c, in_d} = {a, b, c, d};
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_res(output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      cyc++;
      ok = res_valid;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (level !== 3'd0) begin miscompares++; $display("FAIL reset_level got %0d exp 0", level); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    vectors++; if (eng_start !== 1'b0) begin miscompares++; $display("FAIL reset_eng_start got %b exp 0", eng_start); end
    vectors++; if ({eng_a, eng_b, eng_c, eng_d} !== 32'h0) begin miscompares++; $display("FAIL reset_eng_ops got %h exp 0", {eng_a, eng_b, eng_c, eng_d}); end
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
    vectors++; if (res_data !== 16'd0) begin miscompares++; $display("FAIL reset_res_data got %0d exp 0", res_data); end
    vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", err_timeout); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    bit ok;
    int cyc;
    push_tuple(8'd1, 8'd2, 8'd3, 8'd4);
    vectors++; if (eng_start !== 1'b0) begin miscompares++; $display("FAIL single_start_e0 got %b exp 0", eng_start); end
    vectors++; if (level !== 3'd1) begin miscompares++; $display("FAIL single_level_e0 got %0d exp 1", level); end
    @(negedge clk);
    vectors++; if (eng_start !== 1'b1) begin miscompares++; $display("FAIL single_start_e1 got %b exp 1", eng_start); end
    vectors++; if ({eng_a, eng_b, eng_c, eng_d} !== 32'h01020304) begin miscompares++; $display("FAIL single_ops_e1 got %h exp 01020304", {eng_a, eng_b, eng_c, eng_d}); end
    @(negedge clk);
    vectors++; if (eng_start !== 1'b1) begin miscompares++; $display("FAIL single_start_e2 got %b exp 1", eng_start); end
    @(negedge clk);
    vectors++; if (eng_start !== 1'b0) begin miscompares++; $display("FAIL single_start_e3 got %b exp 0", eng_start); end
    wait_res(ok, cyc);
    vectors++; if (!ok || cyc + 3 !== 6) begin miscompares++; $display("FAIL single_latency got %0d (valid %b) exp 6", cyc + 3, ok); end
    vectors++; if (res_data !== 16'd10) begin miscompares++; $display("FAIL single_data got %0d exp 10", res_data); end
    vectors++; if ({eng_a, eng_b, eng_c, eng_d} !== 32'h01020304) begin miscompares++; $display("FAIL single_ops_hold got %h exp 01020304", {eng_a, eng_b, eng_c, eng_d}); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp [3] = '{16'd10, 16'd29, 16'd66};
    int n = 0;
    peak = 0;
    viol = 0;
    push_tuple(8'd1, 8'd2, 8'd3, 8'd4);
    push_tuple(8'd2, 8'd3, 8'd4, 8'd5);
    push_tuple(8'd3, 8'd4, 8'd5, 8'd6);
    for (int i = 0; i < 100 && n < 3; i++) begin
      if (res_valid) begin
        vectors++; if (res_data !== exp[n]) begin miscompares++; $display("FAIL b2b_result%0d got %0d exp %0d", n, res_data, exp[n]); end
        n++;
      end
      @(negedge clk);
    end
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL b2b_count got %0d exp 3", n); end
    vectors++; if (peak < 2) begin miscompares++; $display("FAIL b2b_peak_level got %0d exp >=2", peak); end
    vectors++; if (viol !== 0) begin miscompares++; $display("FAIL b2b_start_while_busy got %0d exp 0", viol); end
  endtask

  task automatic test_backpressure;
    logic [15:0] exp [6] = '{16'd7, 16'd14, 16'd21, 16'd28, 16'd35, 16'd42};
    int n = 1;
    bit taken = 1'b0;
    bit accept;
    res_ready = 1'b0;
    for (int k = 1; k <= 5; k++) push_tuple(8'(k), 8'd2, 8'd3, 8'(k));
    in_valid = 1'b1;
    {in_a, in_b, in_c, in_d} = {8'd6, 8'd2, 8'd3, 8'd6};
    repeat (10) @(negedge clk);
    vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL bp_res_valid got %b exp 1", res_valid); end
    vectors++; if (res_data !== exp[0]) begin miscompares++; $display("FAIL bp_result0 got %0d exp %0d", res_data, exp[0]); end
    vectors++; if (level !== 3'd4) begin miscompares++; $display("FAIL bp_level got %0d exp 4", level); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
    vectors++; if (eng_start !== 1'b0 || e_busy !== 1'b0) begin miscompares++; $display("FAIL bp_second_issue got start %b busy %b exp 0 0", eng_start, e_busy); end
    res_ready = 1'b1;
    accept = in_valid && in_ready;
    for (int i = 0; i < 200 && n < 6; i++) begin
      @(negedge clk);
      if (accept) begin
        in_valid = 1'b0;
        taken = 1'b1;
      end
      accept = in_valid && in_ready;
      if (res_valid) begin
        vectors++; if (res_data !== exp[n]) begin miscompares++; $display("FAIL bp_result%0d got %0d exp %0d", n, res_data, exp[n]); end
        n++;
      end
    end
    in_valid = 1'b0;
    vectors++; if (n !== 6 || !taken) begin miscompares++; $display("FAIL bp_drain got %0d results (6th taken %b) exp 6", n, taken); end
    @(negedge clk);
    vectors++; if (level !== 3'd0) begin miscompares++; $display("FAIL bp_level_end got %0d exp 0", level); end
  endtask

  task automatic test_overflow;
    bit ok;
    int cyc;
    push_tuple(8'd255, 8'd255, 8'd255, 8'd255);
    wait_res(ok, cyc);
    vectors++; if (!ok || res_data !== 16'd1022) begin miscompares++; $display("FAIL overflow_data got %0d (valid %b) exp 1022", res_data, ok); end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    bit ok;
    int cyc;
    dead = 1'b1;
    push_tuple(8'd2, 8'd2, 8'd2, 8'd2);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 15) begin
        vectors++; if (eng_start !== 1'b1 || err_timeout !== 1'b0) begin miscompares++; $display("FAIL to_before got start %b err %b exp 1 0", eng_start, err_timeout); end
      end
    end
    vectors++; if (eng_start !== 1'b0) begin miscompares++; $display("FAIL to_start_fall got %b exp 0", eng_start); end
    vectors++; if (err_timeout !== 1'b1) begin miscompares++; $display("FAIL to_err got %b exp 1", err_timeout); end
    vectors++; if (level !== 3'd0 || res_valid !== 1'b0) begin miscompares++; $display("FAIL to_dropped got level %0d valid %b exp 0 0", level, res_valid); end
    dead = 1'b0;
    push_tuple(8'd1, 8'd1, 8'd1, 8'd1);
    wait_res(ok, cyc);
    vectors++; if (!ok || res_data !== 16'd2) begin miscompares++; $display("FAIL to_recover got %0d (valid %b) exp 2", res_data, ok); end
    vectors++; if (err_timeout !== 1'b1) begin miscompares++; $display("FAIL to_sticky got %b exp 1", err_timeout); end
    @(negedge clk);
  endtask

  task automatic test_reset_midop;
    bit ok;
    int cyc;
    push_tuple(8'd3, 8'd3, 8'd3, 8'd3);
    for (int i = 0; i < 20 && !e_busy; i++) @(negedge clk);
    vectors++; if (e_busy !== 1'b1) begin miscompares++; $display("FAIL rst_mid_busy got %b exp 1", e_busy); end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    vectors++; if (eng_start !== 1'b0 || res_valid !== 1'b0 || level !== 3'd0) begin miscompares++; $display("FAIL rst_mid_state got start %b valid %b level %0d exp 0 0 0", eng_start, res_valid, level); end
    vectors++; if (err_timeout !== 1'b0 || {eng_a, eng_b, eng_c, eng_d} !== 32'h0) begin miscompares++; $display("FAIL rst_mid_regs got err %b ops %h exp 0 0", err_timeout, {eng_a, eng_b, eng_c, eng_d}); end
    vectors++; if (e_busy !== 1'b1) begin miscompares++; $display("FAIL rst_mid_engine got busy %b exp 1", e_busy); end
    push_tuple(8'd4, 8'd5, 8'd6, 8'd7);
    for (int i = 0; i < 10 && e_busy; i++) begin
      vectors++; if (eng_start !== 1'b0) begin miscompares++; $display("FAIL rst_mid_sync got start %b exp 0", eng_start); end
      @(negedge clk);
    end
    wait_res(ok, cyc);
    vectors++; if (!ok || res_data !== 16'd127) begin miscompares++; $display("FAIL rst_mid_result got %0d (valid %b) exp 127", res_data, ok); end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_single;
    test_back_to_back;
    test_backpressure;
    test_overflow;
    test_timeout;
    test_reset_midop;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
